sram_access_ctrl: RTL and testbench

Sequencing controller for one width-configurable SRAM macro, 32 columns wide, with 32/16/8-bit word modes. It holds the active width configuration and accepts one read or write request at a time over a valid/ready port. It splits the word address into a row and a lane segment, and drives precharge, wordline and write enable in a fixed phase sequence. It returns read data extracted and zero-extended from the selected lane. Its sram_seg/sram_conf outputs feed the bitline-mask decoder.

---
 rtl/sram_ctrl_pkg.sv | 20 ++
 rtl/sram_access_ctrl_if.sv | 22 ++
 rtl/sram_lane_align.sv | 41 ++++
 rtl/sram_access_ctrl.sv | 121 ++++++++++++
 tb/tb_sram_access_ctrl.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared encodings for the width-configurable SRAM access controller.
package sram_ctrl_pkg;

    localparam logic [1:0] CONF_W32  = 2'd0;
    localparam logic [1:0] CONF_W16  = 2'd1;
    localparam logic [1:0] CONF_W8   = 2'd2;
    localparam logic [1:0] CONF_RSVD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_ACC  = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    function automatic logic conf_legal(input logic [1:0] c);
        return c != CONF_RSVD;
    endfunction

endpackage

// File: rtl/sram_access_ctrl_if.sv
// Request/response handshake between a client (master) and the controller (slave).
interface sram_access_ctrl_if #(
    parameter int ROW_BITS = 5
);
    logic                req_valid;
    logic                req_ready;
    logic                req_we;
    logic [ROW_BITS+1:0] req_addr;
    logic [31:0]         req_wdata;
    logic                rsp_valid;
    logic [31:0]         rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sram_lane_align.sv
// Width-dependent address split, write-lane replication and read-lane extraction.
module sram_lane_align
    import sram_ctrl_pkg::*;
#(
    parameter int ROW_BITS = 5
) (
    input  logic [1:0]          conf,
    input  logic [ROW_BITS+1:0] addr,
    input  logic [31:0]         wdata,
    input  logic [1:0]          rd_seg,
    input  logic [31:0]         raw,
    output logic [ROW_BITS-1:0] row,
    output logic [1:0]          seg,
    output logic [31:0]         wdata_rep,
    output logic [31:0]         rdata
);

    always_comb begin
        row       = addr[ROW_BITS-1:0];
        seg       = 2'd0;
        wdata_rep = wdata;
        rdata     = raw;
        case (conf)
            CONF_W32: ;
            CONF_W16: begin
                row       = addr[ROW_BITS:1];
                seg       = {1'b0, addr[0]};
                wdata_rep = {2{wdata[15:0]}};
                rdata     = {16'h0, rd_seg[0] ? raw[31:16] : raw[15:0]};
            end
            CONF_W8: begin
                row       = addr[ROW_BITS+1:2];
                seg       = addr[1:0];
                wdata_rep = {4{wdata[7:0]}};
                rdata     = {24'h0, raw[{rd_seg, 3'b000} +: 8]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sram_access_ctrl.sv
// Single-outstanding SRAM sequencer: IDLE -> PRE -> ACC (ACC_CYCLES) -> RESP.
module sram_access_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ROW_BITS   = 5,
    parameter int ACC_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [1:0]          cfg_conf,
    output logic [1:0]          conf,
    sram_access_ctrl_if.slave   bus,
    output logic [ROW_BITS-1:0] sram_row,
    output logic [1:0]          sram_seg,
    output logic [1:0]          sram_conf,
    output logic                sram_pre,
    output logic                sram_wl_en,
    output logic                sram_we,
    output logic [31:0]         sram_wdata,
    input  logic [31:0]         sram_rdata
);

    localparam logic [3:0] ACC_LAST = 4'(ACC_CYCLES - 1);

    state_t              state, state_n;
    logic [3:0]          cnt;
    logic                acc_we;
    logic                pend_vld;
    logic [1:0]          pend_conf;
    logic                accept;
    logic                cfg_ok;
    logic [ROW_BITS-1:0] row_a;
    logic [1:0]          seg_a;
    logic [31:0]         wdata_a;
    logic [31:0]         rdata_a;

    assign accept    = (state == ST_IDLE) && bus.req_valid && bus.req_ready;
    assign cfg_ok    = cfg_we && conf_legal(cfg_conf);
    assign sram_conf = conf;

    // conf can only move in IDLE or on RESP->IDLE, so it equals the
    // acceptance-time conf for the whole access.
    sram_lane_align #(.ROW_BITS(ROW_BITS)) u_align (
        .conf      (conf),
        .addr      (bus.req_addr),
        .wdata     (bus.req_wdata),
        .rd_seg    (sram_seg),
        .raw       (sram_rdata),
        .row       (row_a),
        .seg       (seg_a),
        .wdata_rep (wdata_a),
        .rdata     (rdata_a)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (accept) state_n = ST_PRE;
            ST_PRE:  state_n = ST_ACC;
            ST_ACC:  if (cnt == ACC_LAST) state_n = ST_RESP;
            ST_RESP: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.req_ready <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            sram_pre      <= 1'b0;
            sram_wl_en    <= 1'b0;
            sram_we       <= 1'b0;
            sram_row      <= '0;
            sram_seg      <= '0;
            sram_wdata    <= '0;
            cnt           <= '0;
            acc_we        <= 1'b0;
            conf          <= CONF_W32;
            pend_vld      <= 1'b0;
            pend_conf     <= CONF_W32;
        end else begin
            bus.req_ready <= state_n == ST_IDLE;
            bus.rsp_valid <= state_n == ST_RESP;
            sram_pre      <= state_n == ST_PRE;
            sram_wl_en    <= state_n == ST_ACC;
            sram_we       <= (state_n == ST_ACC) && acc_we;
            cnt           <= (state == ST_ACC) ? cnt + 4'd1 : 4'd0;

            if (accept) begin
                acc_we     <= bus.req_we;
                sram_row   <= row_a;
                sram_seg   <= seg_a;
                sram_wdata <= wdata_a;
            end

            if (state == ST_ACC && state_n == ST_RESP)
                bus.rsp_rdata <= acc_we ? 32'h0 : rdata_a;

            // A write landing in RESP is the newest pending value, so it wins.
            if (state == ST_IDLE && !accept) begin
                if (cfg_ok) conf <= cfg_conf;
            end else if (state_n == ST_IDLE) begin
                pend_vld <= 1'b0;
                if (cfg_ok)        conf <= cfg_conf;
                else if (pend_vld) conf <= pend_conf;
            end else if (cfg_ok) begin
                pend_vld  <= 1'b1;
                pend_conf <= cfg_conf;
            end
        end
    end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Bench for sram_access_ctrl: vector table, hand sequences, random traffic vs a reference model.
module tb_sram_access_ctrl;
    localparam int RB  = 5;
    localparam int ACC = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_conf = 2'd0;
    logic [1:0]  conf, sram_seg, sram_conf;
    logic [RB-1:0] sram_row;
    logic        sram_pre, sram_wl_en, sram_we;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata = 32'h0;

    sram_access_ctrl_if #(.ROW_BITS(RB)) bus ();

    sram_access_ctrl #(.ROW_BITS(RB), .ACC_CYCLES(ACC)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_conf   (cfg_conf),
        .conf       (conf),
        .bus        (bus),
        .sram_row   (sram_row),
        .sram_seg   (sram_seg),
        .sram_conf  (sram_conf),
        .sram_pre   (sram_pre),
        .sram_wl_en (sram_wl_en),
        .sram_we    (sram_we),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [1:0] conf_m = 2'd0;

    typedef struct {
        logic [1:0]  c;
        logic        we;
        logic [6:0]  addr;
        logic [31:0] wd;
        logic [31:0] raw;
        logic [4:0]  row;
        logic [1:0]  seg;
        logic [31:0] rep;
        logic [31:0] rd;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: a word of width 32>>c sits in lane (addr mod lanes) of row (addr div lanes).
    function automatic void model(input logic [1:0] c, input logic we_, input logic [6:0] a,
                                  input logic [31:0] wd, input logic [31:0] raw,
                                  output logic [4:0] row, output logic [1:0] seg,
                                  output logic [31:0] rep, output logic [31:0] rd);
        int n, w;
        longint unsigned m, r;
        n = 1 << c;
        w = 32 / n;
        m = (64'd1 << w) - 64'd1;
        seg = 2'(int'(a) % n);
        row = 5'((int'(a) / n) % 32);
        r = 0;
        for (int i = 0; i < n; i++) r = r | ((longint'(wd) & m) << (w * i));
        rep = 32'(r);
        rd = we_ ? 32'd0 : 32'((longint'(raw) >> (w * int'(seg))) & m);
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, " pre"},   32'(sram_pre), 32'd0);
        chk({tag, " wl"},    32'(sram_wl_en), 32'd0);
        chk({tag, " we"},    32'(sram_we), 32'd0);
        chk({tag, " rsp_v"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, " ready"}, 32'(bus.req_ready), 32'd0);
        chk({tag, " rdata"}, bus.rsp_rdata, 32'd0);
        chk({tag, " row"},   32'(sram_row), 32'd0);
        chk({tag, " seg"},   32'(sram_seg), 32'd0);
        chk({tag, " wdata"}, sram_wdata, 32'd0);
        chk({tag, " conf"},  32'(conf), 32'd0);
    endtask

    task automatic set_conf(input logic [1:0] c);
        cfg_we = 1'b1;
        cfg_conf = c;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        if (c != 2'd3) conf_m = c;
        chk("cfg conf", 32'(conf), 32'(conf_m));
        chk("cfg sram_conf", 32'(sram_conf), 32'(conf_m));
        chk("cfg ready", 32'(bus.req_ready), 32'd1);
    endtask

    // One access; optional cfg_we injected at cycle inj (0 = acceptance cycle).
    task automatic xact(input string tag, input logic we, input logic [6:0] addr,
                        input logic [31:0] wd, input logic [31:0] raw,
                        input logic [4:0] erow, input logic [1:0] eseg,
                        input logic [31:0] erep, input logic [31:0] erd,
                        input int inj, input logic [1:0] inj_c);
        int lat = -1, pre_at = -1, wl_first = -1, n_pre = 0, n_wl = 0, n_we = 0;
        bit busy_bad = 0;
        logic [1:0] c_old = conf_m;
        logic [4:0] g_row = '0;
        logic [1:0] g_seg = '0;
        logic [31:0] g_wd = '0, g_rd = '0;
        for (int i = 0; i < 20 && !bus.req_ready; i++) begin @(posedge clk); #1; end
        chk({tag, " ready_in"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_we = we;
        bus.req_addr = addr;
        bus.req_wdata = wd;
        sram_rdata = raw;
        if (inj == 0) begin cfg_we = 1'b1; cfg_conf = inj_c; end
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(posedge clk); #1;
            bus.req_valid = 1'b0;
            cfg_we = 1'b0;
            if (inj == cyc) begin cfg_we = 1'b1; cfg_conf = inj_c; end
            if (sram_pre) begin n_pre++; if (pre_at < 0) pre_at = cyc; end
            if (sram_wl_en) begin n_wl++; if (wl_first < 0) wl_first = cyc; end
            if (sram_we) n_we++;
            if (bus.req_ready || conf != c_old) busy_bad = 1;
            if (cyc == 1) begin g_row = sram_row; g_seg = sram_seg; g_wd = sram_wdata; end
            if (bus.rsp_valid) begin lat = cyc; g_rd = bus.rsp_rdata; break; end
        end
        chk({tag, " latency"},  32'(lat), 32'(ACC + 2));
        chk({tag, " pre_at"},   32'(pre_at), 32'd1);
        chk({tag, " n_pre"},    32'(n_pre), 32'd1);
        chk({tag, " wl_first"}, 32'(wl_first), 32'd2);
        chk({tag, " n_wl"},     32'(n_wl), 32'(ACC));
        chk({tag, " n_we"},     32'(n_we), we ? 32'(ACC) : 32'd0);
        chk({tag, " row"},      32'(g_row), 32'(erow));
        chk({tag, " seg"},      32'(g_seg), 32'(eseg));
        chk({tag, " wdata"},    g_wd, erep);
        chk({tag, " rdata"},    g_rd, erd);
        chk({tag, " busy"},     32'(busy_bad), 32'd0);
        @(posedge clk); #1;
        cfg_we = 1'b0;
        if (inj >= 0 && inj_c != 2'd3) conf_m = inj_c;
        chk({tag, " rsp_pulse"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, " conf_after"}, 32'(conf), 32'(conf_m));
        chk({tag, " ready_after"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] r; logic [1:0] s; logic [31:0] rp, rd;
        logic we; logic [6:0] a; logic [31:0] wd, raw;
        int inj; logic [1:0] ic;
        bit bad;

        vt[0] = '{2'd0, 1'b1, 7'd3,    32'hDEADBEEF, 32'h0,        5'd3,  2'd0, 32'hDEADBEEF, 32'h0};
        vt[1] = '{2'd0, 1'b0, 7'd3,    32'h0,        32'hDEADBEEF, 5'd3,  2'd0, 32'h0,        32'hDEADBEEF};
        vt[2] = '{2'd2, 1'b1, 7'd6,    32'h5A,       32'h0,        5'd1,  2'd2, 32'h5A5A5A5A, 32'h0};
        vt[3] = '{2'd2, 1'b0, 7'd6,    32'h0,        32'h11223344, 5'd1,  2'd2, 32'h0,        32'h22};
        vt[4] = '{2'd1, 1'b0, 7'd5,    32'h0,        32'hABCD1234, 5'd2,  2'd1, 32'h0,        32'hABCD};
        vt[5] = '{2'd1, 1'b0, 7'd4,    32'h0,        32'hABCD1234, 5'd2,  2'd0, 32'h0,        32'h1234};
        vt[6] = '{2'd1, 1'b1, 7'h7F,   32'hFFFF1234, 32'h0,        5'd31, 2'd1, 32'h12341234, 32'h0};
        vt[7] = '{2'd2, 1'b0, 7'h7F,   32'h0,        32'hA1B2C3D4, 5'd31, 2'd3, 32'h0,        32'hA1};
        vt[8] = '{2'd0, 1'b1, 7'h65,   32'h0BADF00D, 32'h0,        5'd5,  2'd0, 32'h0BADF00D, 32'h0};

        bus.req_valid = 1'b0;
        bus.req_we = 1'b0;
        bus.req_addr = '0;
        bus.req_wdata = '0;

        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_reset ready", 32'(bus.req_ready), 32'd1);

        foreach (vt[i]) begin
            set_conf(vt[i].c);
            xact($sformatf("vec%0d", i), vt[i].we, vt[i].addr, vt[i].wd, vt[i].raw,
                 vt[i].row, vt[i].seg, vt[i].rep, vt[i].rd, -1, 2'd0);
        end

        // Config change during ACC must wait for IDLE and not touch the 16-bit read.
        set_conf(2'd1);
        xact("cfg_in_acc", 1'b0, 7'd5, 32'h0, 32'hABCD1234, 5'd2, 2'd1, 32'h0, 32'hABCD, 3, 2'd2);
        xact("after_cfg", 1'b1, 7'd6, 32'h5A, 32'h0, 5'd1, 2'd2, 32'h5A5A5A5A, 32'h0, -1, 2'd0);

        set_conf(2'd3);

        // Asynchronous reset in the middle of ACC.
        bus.req_valid = 1'b1;
        bus.req_we = 1'b1;
        bus.req_addr = 7'd9;
        bus.req_wdata = 32'h77;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid in_acc", 32'(sram_wl_en), 32'd1);
        rst = 1'b1;
        #1;
        chk_zero("rst_mid");
        conf_m = 2'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid) bad = 1;
        end
        chk("rst_mid no_rsp", 32'(bad), 32'd0);
        chk("rst_mid ready", 32'(bus.req_ready), 32'd1);
        xact("post_rst", 1'b0, 7'd3, 32'h0, 32'h12345678, 5'd3, 2'd0, 32'h0, 32'h12345678, -1, 2'd0);

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(2) == 0) set_conf(2'($urandom_range(3)));
            we  = 1'($urandom_range(1));
            a   = 7'($urandom);
            wd  = $urandom;
            raw = $urandom;
            inj = ($urandom_range(3) == 0) ? int'($urandom_range(ACC + 2)) : -1;
            ic  = 2'($urandom_range(3));
            model(conf_m, we, a, wd, raw, r, s, rp, rd);
            xact($sformatf("rnd%0d", k), we, a, wd, raw, r, s, rp, rd, inj, ic);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
